// File: rtl/collision_matrix_detector_if.sv
// ============================================================================
// Module   : collision_matrix_detector_if
// Purpose  : Draw-flag and collision-flag bundle between the object drawers and
//            collision_matrix_detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface collision_matrix_detector_if #(
   parameter int NUM_OBJ = 8
);
   localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;

   logic                 clear;
   logic                 startOfFrame;
   logic [NUM_OBJ-1:0]   draw;
   logic [NUM_PAIRS-1:0] live_hit;
   logic [NUM_PAIRS-1:0] frame_hit;
   logic [NUM_PAIRS-1:0] pair_event;
   logic [NUM_OBJ-1:0]   obj_hit;
   logic                 frame_valid;

   modport master (
      output clear, startOfFrame, draw,
      input  live_hit, frame_hit, pair_event, obj_hit, frame_valid
   );

   modport slave (
      input  clear, startOfFrame, draw,
      output live_hit, frame_hit, pair_event, obj_hit, frame_valid
   );
endinterface

`default_nettype wire

// File: rtl/collision_matrix_detector.sv
// ============================================================================
// Module   : collision_matrix_detector
// Purpose  : Per-pair object overlap detector (live, per-frame sticky, new-hit
//            events). Optional event holdoff enabled by COLLISION_HOLDOFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_matrix_detector #(
   parameter int                                 NUM_OBJ        = 8,
   parameter logic [NUM_OBJ*(NUM_OBJ-1)/2-1:0]   PAIR_MASK      = '1,
   parameter int                                 HOLDOFF_FRAMES = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   collision_matrix_detector_if.slave bus
);
   localparam int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2;

   // Bit set for every pair index (enumeration order (0,1),(0,2)..) containing k.
   function automatic logic [NUM_PAIRS-1:0] pairsOf(input int k);
      logic [NUM_PAIRS-1:0] m;
      int                   p;
      m = '0;
      p = 0;
      for (int i = 0; i < NUM_OBJ - 1; i++) begin
         for (int j = i + 1; j < NUM_OBJ; j++) begin
            if (i == k || j == k) m = m | (NUM_PAIRS'(1) << p);
            p++;
         end
      end
      return m;
   endfunction

   logic [NUM_PAIRS-1:0] w_liveHit;
   logic [NUM_PAIRS-1:0] w_rawEvent;
   logic [NUM_PAIRS-1:0] w_pairEvent;
   logic [NUM_OBJ-1:0]   w_objHit;
   logic [NUM_PAIRS-1:0] r_acc;
   logic [NUM_PAIRS-1:0] r_frameHit;
   logic [NUM_PAIRS-1:0] r_pairEvent;
   logic                 r_frameValid;

   generate
      for (genvar i = 0; i < NUM_OBJ - 1; i++) begin : g_rowI
         for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_colJ
            localparam int c_pairIdx = i * (2 * NUM_OBJ - i - 1) / 2 + (j - i - 1);
            assign w_liveHit[c_pairIdx] = bus.draw[i] & bus.draw[j] & PAIR_MASK[c_pairIdx];
         end
      end

      for (genvar k = 0; k < NUM_OBJ; k++) begin : g_obj
         localparam logic [NUM_PAIRS-1:0] c_objPairs = pairsOf(k);
         assign w_objHit[k] = |(r_frameHit & c_objPairs);
      end
   endgenerate

   assign w_rawEvent = r_acc & ~r_frameHit;

`ifdef COLLISION_HOLDOFF_EN
   localparam int                  c_cntW     = $clog2(HOLDOFF_FRAMES + 1);
   localparam logic [c_cntW-1:0]   c_holdLoad = c_cntW'(HOLDOFF_FRAMES);
   localparam logic [c_cntW-1:0]   c_one      = c_cntW'(1);

   generate
      for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_holdoff
         logic [c_cntW-1:0] r_holdCnt;

         assign w_pairEvent[p] = w_rawEvent[p] & (r_holdCnt == '0);

         // Counter ticks once per frame boundary; a fresh event reloads it.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_holdCnt <= '0;
            end else if (bus.clear) begin
               r_holdCnt <= '0;
            end else if (bus.startOfFrame) begin
               if (r_holdCnt != '0) r_holdCnt <= r_holdCnt - c_one;
               else if (w_rawEvent[p]) r_holdCnt <= c_holdLoad;
            end
         end
      end
   endgenerate
`else
   localparam int c_unusedHoldoff = HOLDOFF_FRAMES;
   assign w_pairEvent = w_rawEvent;
`endif

   // The SOF-cycle pixel seeds the new frame's accumulator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc        <= '0;
         r_frameHit   <= '0;
         r_pairEvent  <= '0;
         r_frameValid <= 1'b0;
      end else if (bus.clear) begin
         r_acc        <= '0;
         r_frameHit   <= '0;
         r_pairEvent  <= '0;
         r_frameValid <= 1'b0;
      end else if (bus.startOfFrame) begin
         r_frameHit   <= r_acc & PAIR_MASK;
         r_pairEvent  <= w_pairEvent & PAIR_MASK;
         r_acc        <= w_liveHit;
         r_frameValid <= 1'b1;
      end else begin
         r_acc        <= r_acc | w_liveHit;
         r_pairEvent  <= '0;
         r_frameValid <= 1'b0;
      end
   end

   assign bus.live_hit    = w_liveHit;
   assign bus.frame_hit   = r_frameHit;
   assign bus.pair_event  = r_pairEvent;
   assign bus.obj_hit     = w_objHit;
   assign bus.frame_valid = r_frameValid;

endmodule

`default_nettype wire

// File: tb/tb_collision_matrix_detector.sv
// ============================================================================
// Module   : tb_collision_matrix_detector
// Purpose  : Self-checking bench for collision_matrix_detector (4 objects,
//            full-mask and partial-mask instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_matrix_detector;
   localparam int          HF     = 2;
   localparam logic [5:0]  MASK_A = 6'b111111;
   localparam logic [5:0]  MASK_M = 6'b011111;

   logic clk;
   logic reset;
   int   nCmp;
   int   nFail;

   collision_matrix_detector_if #(.NUM_OBJ(4)) busA ();
   collision_matrix_detector_if #(.NUM_OBJ(4)) busM ();

   collision_matrix_detector #(.NUM_OBJ(4), .PAIR_MASK(MASK_A), .HOLDOFF_FRAMES(HF)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   collision_matrix_detector #(.NUM_OBJ(4), .PAIR_MASK(MASK_M), .HOLDOFF_FRAMES(HF)) dutM (
      .clk   (clk),
      .reset (reset),
      .bus   (busM.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         pairI[6];
   int         pairJ[6];
   logic [3:0] frameQ[$];
   logic [5:0] mFh[2];
   logic [5:0] mEv[2];
   logic       mValid;
   int         mHold[2][6];

   function automatic logic [5:0] liveOf(input logic [3:0] d, input logic [5:0] mask);
      logic [5:0] r;
      r = '0;
      for (int p = 0; p < 6; p++) r[p] = d[pairI[p]] & d[pairJ[p]] & mask[p];
      return r;
   endfunction

   function automatic logic [3:0] objOf(input logic [5:0] fh);
      logic [3:0] r;
      r = '0;
      for (int p = 0; p < 6; p++) if (fh[p]) begin r[pairI[p]] = 1'b1; r[pairJ[p]] = 1'b1; end
      return r;
   endfunction

   task automatic modelReset();
      frameQ.delete();
      mValid = 1'b0;
      for (int u = 0; u < 2; u++) begin
         mFh[u] = '0;
         mEv[u] = '0;
         for (int p = 0; p < 6; p++) mHold[u][p] = 0;
      end
   endtask

   task automatic modelStep(input logic s, input logic c, input logic [3:0] d);
      logic [5:0] nh, raw, msk;
      for (int u = 0; u < 2; u++) begin
         msk = (u == 0) ? MASK_A : MASK_M;
         if (c) begin
            mFh[u] = '0;
            mEv[u] = '0;
            for (int p = 0; p < 6; p++) mHold[u][p] = 0;
         end else if (s) begin
            nh = '0;
            foreach (frameQ[k]) nh |= liveOf(frameQ[k], msk);
            raw = nh & ~mFh[u];
`ifdef COLLISION_HOLDOFF_EN
            for (int p = 0; p < 6; p++) begin
               mEv[u][p] = 1'b0;
               if (mHold[u][p] != 0) mHold[u][p] = mHold[u][p] - 1;
               else if (raw[p]) begin mEv[u][p] = 1'b1; mHold[u][p] = HF; end
            end
`else
            mEv[u] = raw;
`endif
            mFh[u] = nh;
         end else begin
            mEv[u] = '0;
         end
      end
      mValid = s & ~c;
      if (c) frameQ.delete();
      else if (s) begin frameQ.delete(); frameQ.push_back(d); end
      else frameQ.push_back(d);
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyIn(input logic s, input logic c, input logic [3:0] d);
      busA.startOfFrame = s; busA.clear = c; busA.draw = d;
      busM.startOfFrame = s; busM.clear = c; busM.draw = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyIn(1'b0, 1'b0, 4'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      modelReset();
   endtask

   typedef struct {
      logic       sof;
      logic       clr;
      logic [3:0] d;
      logic [5:0] live;
      logic [5:0] fh;
      logic [5:0] ev;
      logic [3:0] obj;
      logic       valid;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic       s, c;
      logic [3:0] d;
      logic       expEv3;

      nCmp  = 0;
      nFail = 0;
      begin
         int p;
         p = 0;
         for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 4; j++) begin pairI[p] = i; pairJ[p] = j; p++; end
      end

      tbl[0]  = '{1'b1, 1'b0, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 4'b0011, 6'b000001, 6'b000000, 6'b000000, 4'b0000, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 4'b0000, 6'b000000, 6'b000001, 6'b000001, 4'b0011, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 4'b0011, 6'b000001, 6'b000001, 6'b000000, 4'b0011, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'b0000, 6'b000000, 6'b000001, 6'b000000, 4'b0011, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 4'b0000, 6'b000000, 6'b000001, 6'b000000, 4'b0011, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'b0111, 6'b001011, 6'b000000, 6'b000000, 4'b0000, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 4'b0000, 6'b000000, 6'b001011, 6'b001011, 4'b0111, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 4'b0011, 6'b000001, 6'b000000, 6'b000000, 4'b0000, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 4'b0011, 6'b000001, 6'b000000, 6'b000000, 4'b0000, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 4'b0000, 1'b1};

      reset = 1'b1;
      doReset();
      chk("reset_fh",    busA.frame_hit,   6'b0);
      chk("reset_ev",    busA.pair_event,  6'b0);
      chk("reset_obj",   busA.obj_hit,     4'b0);
      chk("reset_valid", busA.frame_valid, 1'b0);

      // Table: basic, persistence, SOF boundary, back-to-back SOF, clear with SOF.
      for (int r = 0; r < 14; r++) begin
         applyIn(tbl[r].sof, tbl[r].clr, tbl[r].d);
         chk($sformatf("tbl%0d_live", r), busA.live_hit, tbl[r].live);
         tick();
         chk($sformatf("tbl%0d_fh", r),    busA.frame_hit,   tbl[r].fh);
         chk($sformatf("tbl%0d_ev", r),    busA.pair_event,  tbl[r].ev);
         chk($sformatf("tbl%0d_obj", r),   busA.obj_hit,     tbl[r].obj);
         chk($sformatf("tbl%0d_valid", r), busA.frame_valid, tbl[r].valid);
      end

      // Masked pair (2,3) on the partial-mask instance.
      applyIn(1'b0, 1'b0, 4'b1100);
      chk("mask_live_A", busA.live_hit, 6'b100000);
      chk("mask_live_M", busM.live_hit, 6'b000000);
      tick();
      applyIn(1'b1, 1'b0, 4'b0000);
      tick();
      chk("mask_fh_A",  busA.frame_hit,  6'b100000);
      chk("mask_ev_A",  busA.pair_event, 6'b100000);
      chk("mask_obj_A", busA.obj_hit,    4'b1100);
      chk("mask_fh_M",  busM.frame_hit,  6'b000000);
      chk("mask_ev_M",  busM.pair_event, 6'b000000);
      chk("mask_obj_M", busM.obj_hit,    4'b0000);

      // Asynchronous reset between clock edges.
      applyIn(1'b0, 1'b0, 4'b0000);
      reset = 1'b1;
      #2;
      chk("areset_fh",    busA.frame_hit,   6'b0);
      chk("areset_obj",   busA.obj_hit,     4'b0);
      chk("areset_valid", busA.frame_valid, 1'b0);
      tick();
      reset = 1'b0;
      modelReset();

      // Pair 0 overlaps in frames 1, 3 and 5.
`ifdef COLLISION_HOLDOFF_EN
      expEv3 = 1'b0;
`else
      expEv3 = 1'b1;
`endif
      applyIn(1'b1, 1'b0, 4'b0000);
      tick();
      for (int f = 1; f <= 5; f++) begin
         applyIn(1'b0, 1'b0, (f % 2 == 1) ? 4'b0011 : 4'b0000);
         tick();
         applyIn(1'b1, 1'b0, 4'b0000);
         tick();
         chk($sformatf("hold_f%0d_fh", f), busA.frame_hit, (f % 2 == 1) ? 6'b000001 : 6'b000000);
         chk($sformatf("hold_f%0d_ev", f), busA.pair_event,
             (f == 1 || f == 5) ? 6'b000001 : ((f == 3 && expEv3) ? 6'b000001 : 6'b000000));
      end

      // Randomized run against the reference model.
      doReset();
      for (int n = 0; n < 800; n++) begin
         s = ($urandom_range(0, 7) == 0);
         c = ($urandom_range(0, 63) == 0);
         d = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         applyIn(s, c, d);
         chk("rnd_live_A", busA.live_hit, liveOf(d, MASK_A));
         chk("rnd_live_M", busM.live_hit, liveOf(d, MASK_M));
         tick();
         modelStep(s, c, d);
         chk("rnd_fh_A",    busA.frame_hit,   mFh[0]);
         chk("rnd_ev_A",    busA.pair_event,  mEv[0]);
         chk("rnd_obj_A",   busA.obj_hit,     objOf(mFh[0]));
         chk("rnd_valid_A", busA.frame_valid, mValid);
         chk("rnd_fh_M",    busM.frame_hit,   mFh[1]);
         chk("rnd_ev_M",    busM.pair_event,  mEv[1]);
         chk("rnd_obj_M",   busM.obj_hit,     objOf(mFh[1]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end
endmodule

`default_nettype wire
